uart_cmd_transceiver_p: RTL

- Parametrised next-generation UART command transceiver for the DSO command path.
- RX side assembles CMD_BYTES-byte commands from the serial line. It adds framing-error rejection, inter-byte timeout resync and command-overrun flagging.
- TX side queues response bytes in a small FIFO so the command processor can push multi-byte replies back-to-back.
- Sits between the board-level RX/TX pins and the command-processing FSM.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_cmd_transceiver_p.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command transceiver.
//   rx_state_t : receive FSM states
//   tx_state_t : transmit FSM states
//   UART_DATA_BITS / UART_FRAME_BITS : 8N1 framing sizes
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO that queues response bytes for the UART transmitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : head-of-queue data (valid while !empty)
//   full/empty : occupancy flags
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    // A push into a full FIFO is still accepted when the same cycle pops a slot free.
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_cmd_transceiver_p.sv
// UART command transceiver for the DSO command path.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   RX           : serial input (asynchronous, synchronised internally)
//   TX           : serial output, idles high
//   cmd          : last complete command, first byte received in the MSBs
//   cmd_rdy      : command available; clr_cmd_rdy acknowledges it
//   cmd_ovr      : pulse, command completed while cmd_rdy was still set
//   frm_err      : pulse, stop bit sampled low
//   to_err       : pulse, partial command dropped after inter-byte timeout
//   tx_data/trmt : byte to send and its push strobe into the TX FIFO
//   tx_full      : TX FIFO full
//   tx_busy      : FIFO holds data or a frame is being shifted out
//   tx_done      : pulse at the end of each transmitted stop bit
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a falling edge; inter-byte timeout runs
//   RX_START | half a bit in, confirming the start bit
//   RX_DATA  | sampling 8 data bits LSB first
//   RX_STOP  | sampling the stop bit
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | TX high, waiting for the FIFO to hold a byte
//   TX_BUSY  | shifting a 10-bit frame out
module uart_cmd_transceiver_p
    import uart_pkg::*;
#(
    parameter int BAUD_DIV     = 2604,
    parameter int CMD_BYTES    = 3,
    parameter int TX_DEPTH     = 4,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   RX,
    output logic                   TX,
    output logic [8*CMD_BYTES-1:0] cmd,
    output logic                   cmd_rdy,
    input  logic                   clr_cmd_rdy,
    output logic                   cmd_ovr,
    output logic                   frm_err,
    output logic                   to_err,
    input  logic [7:0]             tx_data,
    input  logic                   trmt,
    output logic                   tx_full,
    output logic                   tx_busy,
    output logic                   tx_done
);

    localparam int CMD_W  = 8 * CMD_BYTES;
    localparam int BIT_W  = $clog2(BAUD_DIV + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_BITS * BAUD_DIV + 1);
    localparam int BYTE_W = $clog2(CMD_BYTES + 1);

    localparam logic [BIT_W-1:0]  BAUD_FULL  = BIT_W'(BAUD_DIV);
    localparam logic [BIT_W-1:0]  BAUD_HALF  = BIT_W'(BAUD_DIV / 2);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_BITS * BAUD_DIV);
    localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(CMD_BYTES - 1);

    // ---------------- RX ----------------
    rx_state_t          rx_state;
    rx_state_t          rx_next;
    logic               rx_meta;
    logic               rx_s;
    logic [BIT_W-1:0]   rx_cnt;
    logic [2:0]         rx_idx;
    logic [7:0]         rx_shift;
    logic [CMD_W-1:0]   cmd_asm;
    logic [BYTE_W-1:0]  byte_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               cmd_done;

    logic               rx_expire;
    logic               rx_load_half;
    logic               rx_load_full;
    logic               rx_sample;
    logic               stop_ok;
    logic               stop_bad;
    logic               idle_run;
    logic               idle_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    // Down-counter expires on its last cycle so a load of N spans exactly N cycles.
    assign rx_expire = (rx_cnt == BIT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_s) rx_next = RX_START;
            RX_START: if (rx_expire) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_expire && (rx_idx == 3'(UART_DATA_BITS - 1))) rx_next = RX_STOP;
            RX_STOP:  if (rx_expire) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_load_half = (rx_state == RX_IDLE) && !rx_s;
        rx_load_full = ((rx_state == RX_START) && rx_expire && !rx_s) ||
                       ((rx_state == RX_DATA) && rx_expire);
        rx_sample    = (rx_state == RX_DATA) && rx_expire;
        stop_ok      = (rx_state == RX_STOP) && rx_expire && rx_s;
        stop_bad     = (rx_state == RX_STOP) && rx_expire && !rx_s;
        // Timeout only matters between bytes of an unfinished command.
        idle_run     = (rx_state == RX_IDLE) && (byte_cnt != '0) && rx_s;
        idle_expire  = idle_run && (idle_cnt == IDLE_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            cmd_asm  <= '0;
            byte_cnt <= '0;
            idle_cnt <= IDLE_LIMIT;
            cmd_done <= 1'b0;
            frm_err  <= 1'b0;
            to_err   <= 1'b0;
        end else begin
            if (rx_load_half) begin
                rx_cnt <= BAUD_HALF;
            end else if (rx_load_full) begin
                rx_cnt <= BAUD_FULL;
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - BIT_W'(1);
            end

            if (rx_state == RX_START) begin
                rx_idx <= '0;
            end else if (rx_sample) begin
                rx_idx <= rx_idx + 3'd1;
            end

            if (rx_sample) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
            end

            if (idle_run) begin
                idle_cnt <= idle_cnt - IDLE_W'(1);
            end else begin
                idle_cnt <= IDLE_LIMIT;
            end

            cmd_done <= stop_ok && (byte_cnt == LAST_BYTE);
            frm_err  <= stop_bad;
            to_err   <= idle_expire;

            if (stop_ok) begin
                cmd_asm <= (cmd_asm << UART_DATA_BITS) | CMD_W'(rx_shift);
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt <= '0;
                end else begin
                    byte_cnt <= byte_cnt + BYTE_W'(1);
                end
            end else if (stop_bad || idle_expire) begin
                byte_cnt <= '0;
            end
        end
    end

    // cmd lags the assembly register by one cycle; a completion beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd     <= '0;
            cmd_rdy <= 1'b0;
            cmd_ovr <= 1'b0;
        end else begin
            cmd_ovr <= cmd_done && cmd_rdy;
            if (cmd_done) begin
                cmd     <= cmd_asm;
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    // ---------------- TX ----------------
    tx_state_t          tx_state;
    tx_state_t          tx_next;
    logic [BIT_W-1:0]   tx_cnt;
    logic [3:0]         tx_idx;
    logic [9:0]         tx_frame;
    logic [7:0]         fifo_dout;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               tx_bit_end;
    logic               frame_end;
    logic               tx_load;

    uart_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (trmt),
        .din   (tx_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (tx_full),
        .empty (fifo_empty)
    );

    assign tx_bit_end = (tx_cnt == BIT_W'(1));
    assign frame_end  = (tx_state == TX_BUSY) && tx_bit_end &&
                        (tx_idx == 4'(UART_FRAME_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (!fifo_empty) tx_next = TX_BUSY;
            TX_BUSY: if (frame_end && fifo_empty) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    // Reloading on the stop-bit's last cycle keeps queued frames back-to-back.
    always_comb begin
        tx_load  = ((tx_state == TX_IDLE) && !fifo_empty) || (frame_end && !fifo_empty);
        fifo_pop = tx_load;
        tx_busy  = !fifo_empty || (tx_state == TX_BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_frame <= '1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= frame_end;
            if (tx_load) begin
                tx_frame <= {1'b1, fifo_dout, 1'b0};
                tx_cnt   <= BAUD_FULL;
                tx_idx   <= '0;
            end else if (tx_state == TX_BUSY) begin
                if (tx_bit_end) begin
                    // Shifting in ones leaves the line idle-high after the stop bit.
                    tx_frame <= {1'b1, tx_frame[9:1]};
                    tx_idx   <= tx_idx + 4'd1;
                    tx_cnt   <= BAUD_FULL;
                end else begin
                    tx_cnt <= tx_cnt - BIT_W'(1);
                end
            end
        end
    end

    assign TX = tx_frame[0];

endmodule
